instr_decode: RTL and testbench



---
 rtl/instr_decode_pkg.sv | 57 +++++
 rtl/instr_decode_reg_file.sv | 64 ++++++
 rtl/instr_decode.sv | 124 ++++++++++++
 tb/tb_instr_decode.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_pkg.sv
// ----------------------------------------------------------------------------
// instr_decode_pkg
// Shared widths, LEGv8 opcode constants, ALU_op encodings and an opcode
// classifier for the decode stage (instr_decode and its register file).
// ----------------------------------------------------------------------------
package instr_decode_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_AW    = $clog2(NUM_REGS);

    // Full 11-bit opcodes
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    // Branch formats only fix the upper opcode bits
    localparam logic [7:0] OPC_CBZ_PFX = 8'b10110100;
    localparam logic [5:0] OPC_B_PFX   = 6'b000101;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,   // address calculation / NOP
        ALU_OP_PASS  = 2'b01,   // pass-through / zero test for branches
        ALU_OP_RTYPE = 2'b10    // operation selected by R-type opcode
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_OTHER,
        CLS_RTYPE,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B
    } instr_class_e;

    function automatic instr_class_e classify(input logic [10:0] opc);
        instr_class_e cls;
        if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR)
            cls = CLS_RTYPE;
        else if (opc == OPC_LDUR)
            cls = CLS_LDUR;
        else if (opc == OPC_STUR)
            cls = CLS_STUR;
        else if (opc[10:3] == OPC_CBZ_PFX)
            cls = CLS_CBZ;
        else if (opc[10:5] == OPC_B_PFX)
            cls = CLS_B;
        else
            cls = CLS_OTHER;
        return cls;
    endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 32 x WORD register file: two combinational read ports, one write port
// committed on the rising clock edge, asynchronous active-low reset.
// X31 is XZR: it always reads zero and writes to it are dropped.
// Optional macro REGFILE_INIT_EN: reset loads X[i] = i instead of zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   raddr1, raddr2    read addresses
//   rdata1, rdata2    read data (current contents, no write bypass)
//   we, waddr, wdata  write enable, address and data
// ----------------------------------------------------------------------------
module reg_file
    import instr_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [WORD-1:0]   wdata,
    output logic [WORD-1:0]   rdata1,
    output logic [WORD-1:0]   rdata2
);

    logic [WORD-1:0] rd_arr [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
`ifdef REGFILE_INIT_EN
            localparam logic [WORD-1:0] RST_VAL = WORD'(gi);
`else
            localparam logic [WORD-1:0] RST_VAL = '0;
`endif
            logic [WORD-1:0] reg_q;
            logic [WORD-1:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (we && (waddr == REG_AW'(gi)))
                    reg_d = wdata;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    reg_q <= RST_VAL;
                else
                    reg_q <= reg_d;
            end

            assign rd_arr[gi] = reg_q;
        end
    endgenerate

    // XZR has no storage; address 31 never matches a write above.
    assign rd_arr[NUM_REGS-1] = '0;

    assign rdata1 = rd_arr[raddr1];
    assign rdata2 = rd_arr[raddr2];

endmodule

// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
// Decode stage of the single-cycle LEGv8 datapath: main control unit,
// register file (reg_file) and immediate sign-extender.
// Optional macro REGFILE_INIT_EN (passed to reg_file): reset loads X[i] = i.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   Instruction     current 32-bit instruction
//   write_data      write-back value for Rd (committed on rising edge)
//   opcode          Instruction[31:21]
//   uncond_branch, branch, mem_read, mem_to_reg, mem_write, ALU_src,
//   reg_write, ALU_op   control outputs
//   read_data1      X[Rn]
//   read_data2      X[Rm] (R-type) or X[Rt] (STUR/CBZ)
//   sign_extended   sign-extended immediate, not shifted
// ----------------------------------------------------------------------------
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_LEN-1:0] Instruction,
    input  logic [WORD-1:0]      write_data,
    output logic [10:0]          opcode,
    output logic                 uncond_branch,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 ALU_src,
    output logic                 reg_write,
    output logic [1:0]           ALU_op,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2,
    output logic [WORD-1:0]      sign_extended
);

    instr_class_e      cls;
    logic              reg2loc;
    alu_op_e           alu_op;
    logic [REG_AW-1:0] rd_rt;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] raddr2;

    assign opcode = Instruction[31:21];
    assign rd_rt  = Instruction[4:0];
    assign rn     = Instruction[9:5];
    assign rm     = Instruction[20:16];
    assign cls    = classify(opcode);

    // Main control unit
    always_comb begin
        reg2loc       = 1'b0;
        ALU_src       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        alu_op        = ALU_OP_ADD;
        case (cls)
            CLS_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALU_OP_RTYPE;
            end
            CLS_LDUR: begin
                ALU_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            CLS_STUR: begin
                reg2loc   = 1'b1;
                ALU_src   = 1'b1;
                mem_write = 1'b1;
            end
            CLS_CBZ: begin
                reg2loc = 1'b1;
                branch  = 1'b1;
                alu_op  = ALU_OP_PASS;
            end
            CLS_B: begin
                uncond_branch = 1'b1;
                alu_op        = ALU_OP_PASS;
            end
            default: ;
        endcase
    end

    assign ALU_op = alu_op;

    // STUR/CBZ read the register named in the Rt field on port 2.
    assign raddr2 = reg2loc ? rd_rt : rm;

    // Immediate extraction; branch offsets stay in instruction-word units.
    always_comb begin
        sign_extended = '0;
        case (cls)
            CLS_LDUR, CLS_STUR:
                sign_extended = {{(WORD-9){Instruction[20]}}, Instruction[20:12]};
            CLS_CBZ:
                sign_extended = {{(WORD-19){Instruction[23]}}, Instruction[23:5]};
            CLS_B:
                sign_extended = {{(WORD-26){Instruction[25]}}, Instruction[25:0]};
            default: ;
        endcase
    end

    reg_file u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rn),
        .raddr2 (raddr2),
        .we     (reg_write),
        .waddr  (rd_rt),
        .wdata  (write_data),
        .rdata1 (read_data1),
        .rdata2 (read_data2)
    );

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instruction;
    logic [63:0] write_data;
    logic [10:0] opcode;
    logic        uncond_branch, branch, mem_read, mem_to_reg, mem_write;
    logic        ALU_src, reg_write;
    logic [1:0]  ALU_op;
    logic [63:0] read_data1, read_data2, sign_extended;

    int errors = 0;
    int checks = 0;

    // Reference register contents; index 31 stays zero (XZR).
    logic [63:0] model_regs [32];

    instr_decode dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Instruction   (Instruction),
        .write_data    (write_data),
        .opcode        (opcode),
        .uncond_branch (uncond_branch),
        .branch        (branch),
        .mem_read      (mem_read),
        .mem_to_reg    (mem_to_reg),
        .mem_write     (mem_write),
        .ALU_src       (ALU_src),
        .reg_write     (reg_write),
        .ALU_op        (ALU_op),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .sign_extended (sign_extended)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
`ifdef REGFILE_INIT_EN
            model_regs[i] = (i == 31) ? 64'd0 : 64'(i);
`else
            model_regs[i] = 64'd0;
`endif
        end
    endtask

    // Instruction kind: 0 other, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ, 5 B
    function automatic int kind_of(input logic [31:0] ins);
        logic [10:0] opc;
        opc = ins[31:21];
        if (opc == 11'b10001011000 || opc == 11'b11001011000 ||
            opc == 11'b10001010000 || opc == 11'b10101010000) return 1;
        if (opc == 11'b11111000010) return 2;
        if (opc == 11'b11111000000) return 3;
        if (ins[31:24] == 8'hB4)     return 4;
        if (ins[31:26] == 6'b000101) return 5;
        return 0;
    endfunction

    // Control table row: reg2loc,ALU_src,mem_to_reg,reg_write,mem_read,
    // mem_write,branch,uncond_branch,ALU_op[1:0]
    function automatic logic [9:0] ctl_of(input int kind);
        case (kind)
            1: return 10'b0001000010;
            2: return 10'b0111100000;
            3: return 10'b1100010000;
            4: return 10'b1000001001;
            5: return 10'b0000000101;
            default: return 10'b0;
        endcase
    endfunction

    // Signed value of a w-bit field starting at lsb, by arithmetic.
    function automatic logic [63:0] field_signed(input logic [31:0] ins, input int lsb, input int w);
        longint val;
        val = longint'((ins >> lsb) & ((32'd1 << w) - 32'd1));
        if (val >= (64'sd1 <<< (w - 1)))
            val = val - (64'sd1 <<< w);
        return 64'(val);
    endfunction

    task automatic check_outputs(input string tag);
        int          kind;
        logic [9:0]  ctl;
        logic [63:0] exp_se;
        logic [4:0]  r2;
        kind = kind_of(Instruction);
        ctl  = ctl_of(kind);
        case (kind)
            2, 3:    exp_se = field_signed(Instruction, 12, 9);
            4:       exp_se = field_signed(Instruction, 5, 19);
            5:       exp_se = field_signed(Instruction, 0, 26);
            default: exp_se = 64'd0;
        endcase
        r2 = ctl[9] ? Instruction[4:0] : Instruction[20:16];
        chk({tag, ".opcode"},        64'(opcode),        64'(Instruction[31:21]));
        chk({tag, ".ALU_src"},       64'(ALU_src),       64'(ctl[8]));
        chk({tag, ".mem_to_reg"},    64'(mem_to_reg),    64'(ctl[7]));
        chk({tag, ".reg_write"},     64'(reg_write),     64'(ctl[6]));
        chk({tag, ".mem_read"},      64'(mem_read),      64'(ctl[5]));
        chk({tag, ".mem_write"},     64'(mem_write),     64'(ctl[4]));
        chk({tag, ".branch"},        64'(branch),        64'(ctl[3]));
        chk({tag, ".uncond_branch"}, 64'(uncond_branch), 64'(ctl[2]));
        chk({tag, ".ALU_op"},        64'(ALU_op),        64'(ctl[1:0]));
        chk({tag, ".read_data1"},    read_data1,         model_regs[Instruction[9:5]]);
        chk({tag, ".read_data2"},    read_data2,         model_regs[r2]);
        chk({tag, ".sign_extended"}, sign_extended,      exp_se);
    endtask

    // Apply one instruction for a full cycle: check outputs, then clock it.
    task automatic step(input string tag, input logic [31:0] ins, input logic [63:0] wd);
        Instruction = ins;
        write_data  = wd;
        #1;
        check_outputs(tag);
        $display("txn %s: instr=%h wdata=%h rd1=%h rd2=%h se=%h", tag, ins, wd,
                 read_data1, read_data2, sign_extended);
        @(posedge clk);
        if (rst_n && ctl_of(kind_of(ins))[6] && ins[4:0] != 5'd31)
            model_regs[ins[4:0]] = wd;
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [10:0] opc, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
        return {opc, rm, 6'd0, rn, rd};
    endfunction

    initial begin
        logic [10:0] rops [4];
        logic [31:0] ins;
        int          sel;
        rops[0] = 11'b10001011000;
        rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000;
        rops[3] = 11'b10101010000;

        // Reset
        rst_n       = 1'b0;
        Instruction = 32'h8B09026A;
        write_data  = 64'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence
        step("add_after_reset", 32'h8B09026A, 64'd5);
        step("ldur_x9", 32'hF84402C9, 64'd20);
        Instruction = 32'h8B09026A;
        #1;
        chk("x9_after_ldur", read_data2, 64'd20);
        step("stur_x11", 32'hF80602CB, 64'd1234);
        Instruction = 32'hF80602CB;
        #1;
        chk("stur_se", sign_extended, 64'd96);
        step("cbz_neg", 32'hB4FFFF6B, 64'd77);
        Instruction = 32'hB4FFFF6B;
        #1;
        chk("cbz_se_neg", sign_extended, 64'hFFFF_FFFF_FFFF_FFFB);
        step("cbz_pos", 32'hB4000109, 64'd78);
        Instruction = 32'hB4000109;
        #1;
        chk("cbz_se_pos", sign_extended, 64'd8);
        chk("cbz_rd2_x9", read_data2, 64'd20);
        step("b_pos", 32'h14000040, 64'd99);
        Instruction = 32'h14000040;
        #1;
        chk("b_se_pos", sign_extended, 64'd64);
        step("b_neg", 32'h17FFFFC9, 64'd98);
        Instruction = 32'h17FFFFC9;
        #1;
        chk("b_se_neg", sign_extended, 64'hFFFF_FFFF_FFFF_FFC9);
        step("add_x9_chk", 32'h8B09026A, 64'hDEAD);
        step("add_to_xzr", 32'h8B09027F, 64'd30);
        Instruction = mk_r(11'b10001011000, 5'd9, 5'd31, 5'd0);
        #1;
        chk("xzr_reads_zero", read_data1, 64'd0);
        chk("x9_not_overwritten", read_data2, 64'd20);

        // Reset asserted mid-cycle while a write is pending
        Instruction = 32'hF84402C9;
        write_data  = 64'd777;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++)
            step("rst_sweep", mk_r(11'b10001011000, 5'((r + 1) % 32), 5'(r), 5'(r)), 64'hBAD0 + 64'(r));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int r = 0; r < 32; r++) begin
            Instruction = mk_r(11'b10001010000, 5'(31 - r), 5'(r), 5'd31);
            #1;
            check_outputs("post_rst_read");
        end
        @(posedge clk);
        #1;

        // Randomized instruction mix
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1: ins = mk_r(rops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 5'($urandom));
                2:    ins = {11'b11111000010, 9'($urandom), 2'b00, 5'($urandom), 5'($urandom)};
                3:    ins = {11'b11111000000, 9'($urandom), 2'b00, 5'($urandom), 5'($urandom)};
                4:    ins = {8'hB4, 19'($urandom), 5'($urandom)};
                5:    ins = {6'b000101, 26'($urandom)};
                default: ins = $urandom;
            endcase
            step("rand", ins, {$urandom, $urandom});
        end

        // Final register read-back
        for (int r = 0; r < 32; r++) begin
            Instruction = mk_r(11'b10101010000, 5'(r), 5'(r), 5'd31);
            #1;
            check_outputs("final_read");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
